// File: rtl/video_timing_pkg.sv
// Shared geometry defaults, totals and region encoding for video_timing_gen.
// No ports; imported by video_timing_axis and video_timing_gen.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_BACK   = 9;
    localparam int DEF_H_FRONT  = 22;
    localparam int DEF_H_SYNC   = 23;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 23;
    localparam int DEF_V_ACTIVE = 192;
    localparam int DEF_V_FRONT  = 45;
    localparam int DEF_SHIFT_W  = 4;
    localparam int DEF_POS_W    = 10;

    typedef enum logic [1:0] {
        SYNC,
        BACK,
        ACTIVE,
        FRONT
    } region_e;

    function automatic int h_total(
        input int back,
        input int act,
        input int front,
        input int sync
    );
        return back + act + front + sync;
    endfunction

    function automatic int v_total(
        input int sync,
        input int back,
        input int act,
        input int front
    );
        return sync + back + act + front;
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: counter with wrap, region decode and shifted position.
// Ports: clk, reset (async active-low), adv (count enable), shift_l
//   (latched scroll) -> count, wrap (at TOTAL-1), region, pos, in_act.
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int  LEN_SYNC   = 3,
    parameter int  LEN_BACK   = 23,
    parameter int  LEN_ACTIVE = 192,
    parameter int  LEN_FRONT  = 45,
    parameter bit  SYNC_FIRST = 1'b1,
    parameter int  SHIFT_W    = 4,
    parameter int  POS_W      = 10,
    localparam int TOTAL      = LEN_SYNC + LEN_BACK + LEN_ACTIVE + LEN_FRONT,
    localparam int CNT_W      = $clog2(TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv,
    input  logic [SHIFT_W-1:0] shift_l,
    output logic [CNT_W-1:0]   count,
    output logic               wrap,
    output region_e            region,
    output logic [POS_W-1:0]   pos,
    output logic               in_act
);

    // First active count value; sync-first axes put sync ahead of back porch.
    localparam int OFFSET    = SYNC_FIRST ? LEN_SYNC + LEN_BACK : LEN_BACK;
    localparam int ACT_END   = OFFSET + LEN_ACTIVE;
    localparam int FRONT_END = ACT_END + LEN_FRONT;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count = count_q;
    assign wrap  = (count_q == CNT_W'(TOTAL - 1));

    always_comb begin
        count_d = count_q;
        if (adv) begin
            count_d = wrap ? '0 : count_q + CNT_W'(1);
        end
    end

    always_comb begin
        region = FRONT;
        if (SYNC_FIRST) begin
            if (count_q < CNT_W'(LEN_SYNC)) begin
                region = SYNC;
            end else if (count_q < CNT_W'(OFFSET)) begin
                region = BACK;
            end else if (count_q < CNT_W'(ACT_END)) begin
                region = ACTIVE;
            end else begin
                region = FRONT;
            end
        end else begin
            if (count_q < CNT_W'(OFFSET)) begin
                region = BACK;
            end else if (count_q < CNT_W'(ACT_END)) begin
                region = ACTIVE;
            end else if (count_q < CNT_W'(FRONT_END)) begin
                region = FRONT;
            end else begin
                region = SYNC;
            end
        end
    end

    // Zero-extended operands, wrapping two's-complement result.
    assign pos = POS_W'(count_q) - POS_W'(OFFSET) - POS_W'(shift_l);

    assign in_act = !pos[POS_W-1] && (pos < POS_W'(LEN_ACTIVE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: syncs, active flag, signed pixel coordinates.
// Ports: clk, reset (async active-low), hShift, vShift -> hSync, vSync,
//   isActive, xPos, yPos, lineStart, frameStart. With VIDEO_TIMING_IRQ_EN
//   defined adds irqLine, irqAck -> irq (raster line interrupt level).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int SHIFT_W    = DEF_SHIFT_W,
    parameter int POS_W      = DEF_POS_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SHIFT_W-1:0]      hShift,
    input  logic [SHIFT_W-1:0]      vShift,
    output logic                    hSync,
    output logic                    vSync,
    output logic                    isActive,
    output logic signed [POS_W-1:0] xPos,
    output logic signed [POS_W-1:0] yPos,
    output logic                    lineStart,
    output logic                    frameStart
`ifdef VIDEO_TIMING_IRQ_EN
    ,
    input  logic [POS_W-2:0]        irqLine,
    input  logic                    irqAck,
    output logic                    irq
`endif
);

    localparam int H_TOTAL = h_total(H_BACK, H_ACTIVE, H_FRONT, H_SYNC);
    localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    localparam int H_CW    = $clog2(H_TOTAL);
    localparam int V_CW    = $clog2(V_TOTAL);

    logic [H_CW-1:0]    h_count;
    logic [V_CW-1:0]    v_count;
    logic               h_wrap;
    logic               v_wrap;
    region_e            h_region;
    region_e            v_region;
    logic [POS_W-1:0]   h_pos;
    logic [POS_W-1:0]   v_pos;
    logic               h_act;
    logic               v_act;
    logic               frame_end;

    logic [SHIFT_W-1:0] hshift_q, hshift_d;
    logic [SHIFT_W-1:0] vshift_q, vshift_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic [POS_W-1:0]   xpos_q, xpos_d;
    logic [POS_W-1:0]   ypos_q, ypos_d;
    logic               line_q, line_d;
    logic               frame_q, frame_d;

    video_timing_axis #(
        .LEN_SYNC   (H_SYNC),
        .LEN_BACK   (H_BACK),
        .LEN_ACTIVE (H_ACTIVE),
        .LEN_FRONT  (H_FRONT),
        .SYNC_FIRST (1'b0),
        .SHIFT_W    (SHIFT_W),
        .POS_W      (POS_W)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .adv     (1'b1),
        .shift_l (hshift_q),
        .count   (h_count),
        .wrap    (h_wrap),
        .region  (h_region),
        .pos     (h_pos),
        .in_act  (h_act)
    );

    video_timing_axis #(
        .LEN_SYNC   (V_SYNC),
        .LEN_BACK   (V_BACK),
        .LEN_ACTIVE (V_ACTIVE),
        .LEN_FRONT  (V_FRONT),
        .SYNC_FIRST (1'b1),
        .SHIFT_W    (SHIFT_W),
        .POS_W      (POS_W)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .adv     (h_wrap),
        .shift_l (vshift_q),
        .count   (v_count),
        .wrap    (v_wrap),
        .region  (v_region),
        .pos     (v_pos),
        .in_act  (v_act)
    );

    always_comb begin
        // Scroll only changes on the last pixel of a frame: no tearing.
        frame_end = h_wrap && v_wrap;
        hshift_d  = frame_end ? hShift : hshift_q;
        vshift_d  = frame_end ? vShift : vshift_q;
        hsync_d   = (h_region == SYNC) ? H_SYNC_POL : !H_SYNC_POL;
        vsync_d   = (v_region == SYNC) ? V_SYNC_POL : !V_SYNC_POL;
        active_d  = h_act && v_act;
        xpos_d    = h_pos;
        ypos_d    = v_pos;
        line_d    = (h_count == '0);
        frame_d   = line_d && (v_count == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hshift_q <= '0;
            vshift_q <= '0;
            hsync_q  <= !H_SYNC_POL;
            vsync_q  <= !V_SYNC_POL;
            active_q <= 1'b0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            hshift_q <= hshift_d;
            vshift_q <= vshift_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign isActive   = active_q;
    assign xPos       = xpos_q;
    assign yPos       = ypos_q;
    assign lineStart  = line_q;
    assign frameStart = frame_q;

`ifdef VIDEO_TIMING_IRQ_EN
    logic irq_q, irq_d;
    logic irq_hit;

    // A set in the same cycle as an ack wins; lines past V_TOTAL never match.
    always_comb begin
        irq_hit = line_d && (POS_W'(v_count) == POS_W'(irqLine));
        irq_d   = irq_hit || (irq_q && !irqAck);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small-geometry inverted-polarity instance
// and a default instance, checked per cycle plus directed raster checks.
module tb_video_timing_gen;

    localparam int POS_W   = 10;
    localparam int SHIFT_W = 4;

    localparam int A_HA = 8;
    localparam int A_HB = 2;
    localparam int A_HF = 15;
    localparam int A_HS = 3;
    localparam int A_VS = 2;
    localparam int A_VB = 2;
    localparam int A_VA = 4;
    localparam int A_VF = 15;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             act;
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic             ls;
        logic             fs;
        logic             irq;
    } out_t;

    typedef struct {
        int hb;
        int ha;
        int hf;
        int hsy;
        int vsy;
        int vb;
        int va;
        int vf;
        bit hp;
        bit vp;
        int irq_line;
    } geo_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [SHIFT_W-1:0] hShift = '0;
    logic [SHIFT_W-1:0] vShift = '0;

    logic hs_a, vs_a, act_a, ls_a, fs_a, irq_a;
    logic hs_b, vs_b, act_b, ls_b, fs_b, irq_b;
    logic signed [POS_W-1:0] x_a, y_a, x_b, y_b;

`ifdef VIDEO_TIMING_IRQ_EN
    logic irqAck = 1'b0;
    logic [POS_W-2:0] irq_line_a = 9'd10;
    logic [POS_W-2:0] irq_line_b = 9'd300;
`else
    assign irq_a = 1'b0;
    assign irq_b = 1'b0;
`endif

    out_t obs_a, obs_b;
    assign obs_a = {hs_a, vs_a, act_a, x_a, y_a, ls_a, fs_a, irq_a};
    assign obs_b = {hs_b, vs_b, act_b, x_b, y_b, ls_b, fs_b, irq_b};

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE   (A_HA),
        .H_BACK     (A_HB),
        .H_FRONT    (A_HF),
        .H_SYNC     (A_HS),
        .V_SYNC     (A_VS),
        .V_BACK     (A_VB),
        .V_ACTIVE   (A_VA),
        .V_FRONT    (A_VF),
        .H_SYNC_POL (1'b0),
        .V_SYNC_POL (1'b0),
        .SHIFT_W    (SHIFT_W),
        .POS_W      (POS_W)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .hShift     (hShift),
        .vShift     (vShift),
        .hSync      (hs_a),
        .vSync      (vs_a),
        .isActive   (act_a),
        .xPos       (x_a),
        .yPos       (y_a),
        .lineStart  (ls_a),
        .frameStart (fs_a)
`ifdef VIDEO_TIMING_IRQ_EN
        ,
        .irqLine    (irq_line_a),
        .irqAck     (irqAck),
        .irq        (irq_a)
`endif
    );

    video_timing_gen dut_b (
        .clk        (clk),
        .reset      (reset),
        .hShift     (hShift),
        .vShift     (vShift),
        .hSync      (hs_b),
        .vSync      (vs_b),
        .isActive   (act_b),
        .xPos       (x_b),
        .yPos       (y_b),
        .lineStart  (ls_b),
        .frameStart (fs_b)
`ifdef VIDEO_TIMING_IRQ_EN
        ,
        .irqLine    (irq_line_b),
        .irqAck     (irqAck),
        .irq        (irq_b)
`endif
    );

    geo_t geo [2];
    int   mh [2];
    int   mv [2];
    int   msh [2];
    int   msv [2];
    bit   mirq [2];
    out_t sb [$];

    int n_tests = 0;
    int n_fail  = 0;
    int n;
    int cnt;
    int cnt2;

    function automatic int ht(input int d);
        return geo[d].hb + geo[d].ha + geo[d].hf + geo[d].hsy;
    endfunction

    function automatic int vt(input int d);
        return geo[d].vsy + geo[d].vb + geo[d].va + geo[d].vf;
    endfunction

    function automatic out_t model(input int d);
        out_t e;
        int   x;
        int   y;
        x = mh[d] - geo[d].hb - msh[d];
        y = mv[d] - geo[d].vsy - geo[d].vb - msv[d];
        e.hs  = (mh[d] >= ht(d) - geo[d].hsy) ? geo[d].hp : !geo[d].hp;
        e.vs  = (mv[d] < geo[d].vsy) ? geo[d].vp : !geo[d].vp;
        e.act = (x >= 0) && (x < geo[d].ha) && (y >= 0) && (y < geo[d].va);
        e.x   = x[POS_W-1:0];
        e.y   = y[POS_W-1:0];
        e.ls  = (mh[d] == 0);
        e.fs  = (mh[d] == 0) && (mv[d] == 0);
        e.irq = 1'b0;
        return e;
    endfunction

    function automatic out_t rst_exp(input int d);
        out_t e;
        e    = '0;
        e.hs = !geo[d].hp;
        e.vs = !geo[d].vp;
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mh[d]   = 0;
            mv[d]   = 0;
            msh[d]  = 0;
            msv[d]  = 0;
            mirq[d] = 1'b0;
        end
    endtask

    task automatic check(input string tag, input out_t o, input out_t e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic advance(input int d);
        if (mh[d] == ht(d) - 1) begin
            mh[d] = 0;
            if (mv[d] == vt(d) - 1) begin
                mv[d]  = 0;
                msh[d] = int'(hShift);
                msv[d] = int'(vShift);
            end else begin
                mv[d]++;
            end
        end else begin
            mh[d]++;
        end
    endtask

    task automatic step();
        out_t e;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            e = model(d);
`ifdef VIDEO_TIMING_IRQ_EN
            mirq[d] = ((mh[d] == 0) && (mv[d] == geo[d].irq_line))
                      || (mirq[d] && !irqAck);
`endif
            e.irq = mirq[d];
            sb.push_back(e);
            advance(d);
        end
        #1;
        e = sb.pop_front();
        check("a_cycle", obs_a, e);
        e = sb.pop_front();
        check("b_cycle", obs_b, e);
    endtask

    initial begin
        geo[0] = '{A_HB, A_HA, A_HF, A_HS, A_VS, A_VB, A_VA, A_VF,
                   1'b0, 1'b0, 10};
        geo[1] = '{9, 256, 22, 23, 3, 23, 192, 45, 1'b1, 1'b1, 300};
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("a_reset", obs_a, rst_exp(0));
        check("b_reset", obs_b, rst_exp(1));

        reset = 1'b1;
        step();
        check_int("a_first_fs", int'(obs_a.fs), 1);
        check_int("b_first_vs", int'(obs_b.vs), 1);
        check_int("a_first_vs_low", int'(obs_a.vs), 0);

        n = 1;
        while (!obs_b.act && n < 9000) begin
            step();
            n++;
        end
        check_int("b_first_active_step", n, 26 * 310 + 9 + 1);
        check_int("b_first_x", int'(obs_b.x), 0);
        check_int("b_first_y", int'(obs_b.y), 0);

        cnt = 1;
        repeat (300) begin
            step();
            cnt += int'(obs_b.act);
        end
        check_int("b_active_per_line", cnt, 256);

        cnt  = 0;
        cnt2 = 0;
        repeat (310) begin
            step();
            cnt  += int'(obs_b.hs);
            cnt2 += int'(obs_b.ls);
        end
        check_int("b_hsync_cycles", cnt, 23);
        check_int("b_linestart_per_line", cnt2, 1);

        hShift = 4'd5;
        vShift = 4'd3;
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_a.fs && n < 700);
        check_int("a_next_frame_found", int'(obs_a.fs), 1);
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_a.act && n < 700);
        check_int("a_shift_first_active", n, 7 * 28 + 7);
        check_int("a_shift_x", int'(obs_a.x), 0);
        check_int("a_shift_y", int'(obs_a.y), 0);

        n = 0;
        do begin
            step();
            n++;
        end while (!obs_a.act && n < 700);
        check_int("a_active_before_reset", int'(obs_a.act), 1);
        #2;
        reset = 1'b0;
        #1;
        check("a_async_reset", obs_a, rst_exp(0));
        check("b_async_reset", obs_b, rst_exp(1));
        repeat (3) @(posedge clk);
        #1;
        check("a_held_reset", obs_a, rst_exp(0));
        model_reset();
        reset = 1'b1;
        step();
        check_int("a_restart_fs", int'(obs_a.fs), 1);
        check_int("b_restart_fs", int'(obs_b.fs), 1);

`ifdef VIDEO_TIMING_IRQ_EN
        n = 1;
        while (!obs_a.irq && n < 700) begin
            step();
            n++;
        end
        check_int("a_irq_rise_step", n, 10 * 28 + 1);
        check_int("a_irq_with_linestart", int'(obs_a.ls), 1);
        irqAck = 1'b1;
        step();
        irqAck = 1'b0;
        check_int("a_irq_ack_clears", int'(obs_a.irq), 0);
        n = 0;
        while (!(mh[0] == 0 && mv[0] == 10) && n < 1000) begin
            step();
            n++;
        end
        irqAck = 1'b1;
        step();
        check_int("a_irq_set_wins", int'(obs_a.irq), 1);
        step();
        check_int("a_irq_ack_later", int'(obs_a.irq), 0);
        irqAck = 1'b0;
        check_int("b_irq_out_of_range", int'(obs_b.irq), 0);
`endif

        repeat (700) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the video output path. Produces horizontal and vertical sync, an active-region flag and signed pixel coordinates from one pixel clock. Sync geometry and polarities are parameters, not hardwired. Scroll shifts are latched once per frame so scrolling cannot tear mid-frame. Optional raster-line interrupt. Feeds the pixel fetch/render stage and the video DAC/encoder.

## Interface
Parameters:
- H_ACTIVE, 256, active pixels per line
- H_BACK, 9, back-porch cycles before active
- H_FRONT, 22, front-porch cycles after active; must be ≥ 2^SHIFT_W−1
- H_SYNC, 23, hsync cycles; sync occupies the last H_SYNC cycles of the line
- V_SYNC, 3, vsync lines; sync occupies lines 0..V_SYNC−1
- V_BACK, 23, lines between sync and active
- V_ACTIVE, 192, active lines
- V_FRONT, 45, lines after active; must be ≥ 2^SHIFT_W−1
- H_SYNC_POL / V_SYNC_POL, 1 / 1, asserted level of hSync / vSync
- SHIFT_W, 4, width of shift inputs
- POS_W, 10, width of xPos/yPos (signed)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hShift  in  SHIFT_W  horizontal scroll delay (pixels)
- vShift  in  SHIFT_W  vertical scroll delay (lines)
- hSync  out  1  horizontal sync, polarity H_SYNC_POL
- vSync  out  1  vertical sync, polarity V_SYNC_POL
- isActive  out  1  pixel inside shifted active window
- xPos  out  POS_W  signed pixel column
- yPos  out  POS_W  signed pixel line
- lineStart  out  1  one-cycle pulse at hCount=0
- frameStart  out  1  one-cycle pulse at hCount=0, vCount=0
- irqLine  in  POS_W−1  raster interrupt line (VIDEO_TIMING_IRQ_EN only)
- irq  out  1  raster interrupt level (VIDEO_TIMING_IRQ_EN only)
- irqAck  in  1  clears irq (VIDEO_TIMING_IRQ_EN only)

## Operation
- H_TOTAL = H_BACK+H_ACTIVE+H_FRONT+H_SYNC (default 310). V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT (default 263).
- hCount: 0..H_TOTAL−1, wraps to 0. vCount: increments on hCount wrap, 0..V_TOTAL−1, wraps to 0.
- Horizontal order: back porch, active, front porch, sync. Vertical order: sync, back porch, active, front porch.
- Shift latch: hShiftL/vShiftL load hShift/vShift only on the cycle hCount=H_TOTAL−1 and vCount=V_TOTAL−1. Reset value is 0.
- xPos = hCount − H_BACK − hShiftL. yPos = vCount − V_SYNC − V_BACK − vShiftL. Both are computed at POS_W signed width with zero-extended operands.
- isActive = (0 ≤ xPos < H_ACTIVE) && (0 ≤ yPos < V_ACTIVE).
- xPos and yPos are valid and free-running every cycle, including outside the active window (negative before it).
- hSync asserts when hCount ≥ H_TOTAL−H_SYNC. vSync asserts when vCount < V_SYNC.

## Timing
- All outputs are registered: one cycle latency from the counter state they describe.
- Reset values while reset is low:
  - counters 0, hShiftL and vShiftL 0
  - hSync = !H_SYNC_POL, vSync = !V_SYNC_POL
  - isActive 0, xPos 0, yPos 0
  - lineStart 0, frameStart 0, irq 0
- Reset asserted mid-line forces the reset values immediately (asynchronously). After release, the first rising edge advances the counters from (0,0). frameStart pulses one cycle after the first edge that sees (0,0).
- Shift inputs may change any cycle. The effect starts on the first pixel of the next frame, never earlier.
- Frame period is H_TOTAL×V_TOTAL cycles (default 81530).

## Configuration
- VIDEO_TIMING_IRQ_EN defined:
  - irq sets on the cycle after hCount=0 and vCount=irqLine.
  - irq stays high until irqAck is sampled high.
  - If set and irqAck coincide, set wins.
  - An irqLine ≥ V_TOTAL never fires.
- Undefined: the ports irqLine, irqAck and irq are absent and no logic is generated.

## Structure
- Package video_timing_pkg holds:
  - default geometry constants
  - H_TOTAL/V_TOTAL derivation functions
  - region enum {SYNC, BACK, ACTIVE, FRONT}
- Sub-module video_timing_axis is instantiated twice (H and V). Each instance owns one counter, its wrap and region decode, and shift subtraction. Parameters: lengths, sync-first/sync-last ordering, advance enable.

## Test plan
- Defaults, shifts 0, release reset: first isActive=1 appears one cycle after hCount=9, vCount=26, with xPos=0, yPos=0. Exactly 256 consecutive active cycles per line, 192 active lines per frame.
- Defaults: hSync high exactly for hCount 287..309 (23 cycles). vSync high for lines 0..2. frameStart pulses every 81530 cycles. lineStart pulses every 310 cycles.
- Set hShift=5, vShift=3 mid-frame: the current frame is unchanged. The next frame's first active pixel is at hCount=14, vCount=29.
- Assert reset mid-active-line: outputs drop to reset values without a clock edge. After release, the timing restarts from (0,0).
- H_SYNC_POL=0, V_SYNC_POL=0: hSync is low only for hCount 287..309, vSync is low only on lines 0..2, and both are high in reset.
- With VIDEO_TIMING_IRQ_EN, irqLine=100:
  - irq rises one cycle after (hCount=0, vCount=100).
  - irqAck clears it on the next cycle.
  - irqAck held during the set cycle of the following frame leaves irq=1.
